stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: data bits per channel.
REQ-003 SHALL have localparam SW = $clog2(N_IN): select/source index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used when mode=0.
REQ-008 in_valid  input  N_IN  per-channel beat valid.
REQ-009 in_data  input  N_IN*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
REQ-010 in_last  input  N_IN  per-channel end-of-packet flag.
REQ-011 in_ready  output  N_IN  per-channel accept; at most one bit high.
REQ-012 out_valid  output  1  registered beat valid.
REQ-013 out_data  output  WIDTH  registered beat data.
REQ-014 out_last  output  1  registered end-of-packet flag.
REQ-015 out_src  output  SW  index of the channel that supplied the current beat.
REQ-016 out_ready  input  1  downstream accept.

Function
REQ-017 load_en SHALL be (!out_valid || out_ready); the output stage SHALL load only when load_en is high.
REQ-018 A beat transfers on input i when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to out_valid; full throughput of 1 beat/cycle under continuous out_ready=1.
REQ-020 Grant, unlocked, mode=0: grant = sel, granted only if in_valid[sel]; sel >= N_IN SHALL grant nothing.
REQ-021 Grant, unlocked, mode=1: first channel with in_valid set, searching ptr, ptr+1, ... wrapping modulo N_IN.
REQ-022 in_ready[i] SHALL be high only when i == grant, the grant is valid, and load_en is high; in_ready SHALL NOT depend combinationally on in_valid of other channels beyond the grant search.
REQ-023 A transfer with in_last=0 SHALL set lock and record lock_src = grant; while locked, grant SHALL be lock_src regardless of mode, sel or other valids.
REQ-024 A transfer with in_last=1 SHALL clear lock; in mode=1 it SHALL also set ptr = (grant+1) mod N_IN.
REQ-025 Changes to mode or sel while locked SHALL take effect only after the locking packet's last beat.
REQ-026 ptr SHALL NOT change in mode=0.
REQ-027 With out_valid=1 and out_ready=0, out_data, out_last and out_src SHALL hold stable and all in_ready SHALL be 0.
REQ-028 With no valid grant and load_en high, out_valid SHALL go to 0 next cycle; out_data SHALL hold its previous value.

Reset
REQ-029 On rst high, immediately and independently of clk: out_valid=0, out_data=0, out_last=0, out_src=0, ptr=0, lock=0, lock_src=0.
REQ-030 in_ready SHALL be 0 while rst is high; a reset mid-packet SHALL discard the lock and the held beat.

Structure
REQ-031 A shared package stream_mux_pkg SHALL hold the MODE_FIXED/MODE_RR constants and the N_IN range limits.
REQ-032 The round-robin search SHALL be a sub-module rr_pick (inputs req, ptr; outputs grant index, grant valid), purely combinational.
REQ-033 The output register and lock/ptr state SHALL reside in stream_mux_rr; no other storage.

Verification
REQ-034 Reset check: assert rst mid-packet with out_valid=1 -> out_valid=0, in_ready=0 immediately; lock cleared after release.
REQ-035 Fixed mode: mode=0, sel=2, in_valid=4'b1111, data ch2=8'hA5, last=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_src=2.
REQ-036 Round robin: mode=1, all valid, all last=1, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 Packet lock: ch1 sends 3 beats (last on 3rd) while ch0/ch2 valid, sel toggled -> out_src=1 for 3 beats, next grant ch2 (mode=1).
REQ-038 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data stable, in_ready=0; out_ready=1 -> one beat drains per cycle, no loss or duplication.
REQ-039 Idle: all in_valid=0 after a beat drains -> out_valid=0 next cycle, ptr unchanged.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input
//   N_IN_MIN / N_IN_MAX  : supported range of input channel counts
//   wrap_next()          : index increment that wraps at the channel count
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 16;

    // Next channel index after idx, wrapping back to 0 at n.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i         : per-channel request vector
//   ptr_i         : channel with highest priority for this search
//   grant_o       : first requesting channel at or after ptr_i (wrapping)
//   grant_valid_o : high when any channel is requesting
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] grant_o,
    output logic          grant_valid_o
);

    // Walk the channels starting at ptr_i and keep the first requester.
    always_comb begin
        int idx;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = int'(ptr_i);
        for (int k = 0; k < N; k++) begin
            if (!grant_valid_o && (idx < N) && req_i[idx]) begin
                grant_o       = SW'(idx);
                grant_valid_o = 1'b1;
            end else begin
                grant_valid_o = grant_valid_o;
            end
            idx = wrap_next(idx, N);
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with fixed-select or round-robin arbitration,
// packet locking and a single registered output stage.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   mode        : 0 = channel chosen by sel, 1 = round-robin
//   sel         : channel index used in fixed mode
//   in_valid    : per-channel beat valid
//   in_data     : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last     : per-channel end-of-packet flag
//   in_ready    : per-channel accept (one-hot or zero)
//   out_valid   : registered beat valid
//   out_data    : registered beat data
//   out_last    : registered end-of-packet flag
//   out_src     : channel that supplied the current output beat
//   out_ready   : downstream accept
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int WIDTH = 8,
    localparam int SW    = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SW-1:0]         out_src,
    input  logic                  out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [SW-1:0]    out_src_q,   out_src_d;
    logic [SW-1:0]    ptr_q,       ptr_d;
    logic             lock_q,      lock_d;
    logic [SW-1:0]    lock_src_q,  lock_src_d;

    logic             load_en;
    logic [SW-1:0]    grant;
    logic             grant_valid;
    logic [SW-1:0]    rr_grant;
    logic             rr_valid;
    logic             xfer;

    // The output stage can take a new beat when empty or draining this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign xfer    = grant_valid && load_en;

    rr_pick #(
        .N (N_IN)
    ) u_rr_pick (
        .req_i         (in_valid),
        .ptr_i         (ptr_q),
        .grant_o       (rr_grant),
        .grant_valid_o (rr_valid)
    );

    // Grant selection: an open packet owns the mux until its last beat.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (lock_q) begin
            grant       = lock_src_q;
            grant_valid = in_valid[lock_src_q];
        end else if (mode == MODE_FIXED) begin
            // sel beyond the channel count selects nothing
            if (int'(sel) < N_IN) begin
                grant       = sel;
                grant_valid = in_valid[sel];
            end else begin
                grant       = '0;
                grant_valid = 1'b0;
            end
        end else begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
    end

    // One-hot accept toward the granted channel; forced low during reset.
    always_comb begin
        in_ready = '0;
        if (xfer && !rst) begin
            in_ready[grant] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next state of output stage, packet lock and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_src_d  = lock_src_q;
        if (load_en) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = in_data[int'(grant)*WIDTH +: WIDTH];
                out_last_d = in_last[grant];
                out_src_d  = grant;
                if (in_last[grant]) begin
                    lock_d = 1'b0;
                    // Pointer moves past the finished packet's channel only in round-robin.
                    if (mode == MODE_RR) begin
                        ptr_d = SW'(wrap_next(int'(grant), N_IN));
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    lock_d     = 1'b1;
                    lock_src_d = grant;
                end
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_src_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (4 channels, 8-bit data).
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [1:0]    sel;
    logic [3:0]    in_valid;
    logic [31:0]   in_data;
    logic [3:0]    in_last;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic       m_ovalid;
    logic [7:0] m_odata;
    logic       m_olast;
    logic [1:0] m_osrc;
    logic [1:0] m_ptr;
    logic       m_lock;
    logic [1:0] m_lsrc;
    logic [3:0] m_ready;
    logic       m_load;
    bit         m_ok;
    int         m_gnt;

    stream_mux_rr #(.N_IN(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ovalid = 1'b0; m_odata = 8'h00; m_olast = 1'b0; m_osrc = 2'd0;
        m_ptr = 2'd0; m_lock = 1'b0; m_lsrc = 2'd0;
    endtask

    // Decide which channel the rules give the mux this cycle.
    task automatic model_eval();
        m_load = !m_ovalid || out_ready;
        m_ok   = 1'b0;
        m_gnt  = 0;
        if (m_lock) begin
            m_gnt = int'(m_lsrc);
            m_ok  = in_valid[m_gnt];
        end else if (mode == 1'b0) begin
            if (int'(sel) < N) begin
                m_gnt = int'(sel);
                m_ok  = in_valid[m_gnt];
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!m_ok && in_valid[(int'(m_ptr) + k) % N]) begin
                    m_ok  = 1'b1;
                    m_gnt = (int'(m_ptr) + k) % N;
                end
            end
        end
        m_ready = (m_ok && m_load) ? 4'(4'b0001 << m_gnt) : 4'b0000;
    endtask

    // Apply the transfer seen at the clock edge to the model.
    task automatic model_commit();
        model_eval();
        if (m_load) begin
            m_ovalid = m_ok;
            if (m_ok) begin
                m_odata = in_data[m_gnt*W +: W];
                m_olast = in_last[m_gnt];
                m_osrc  = 2'(m_gnt);
                if (in_last[m_gnt]) begin
                    m_lock = 1'b0;
                    if (mode) m_ptr = 2'((m_gnt + 1) % N);
                end else begin
                    m_lock = 1'b1;
                    m_lsrc = 2'(m_gnt);
                end
            end
        end
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; in_last = 4'hF;
        in_data = $urandom; out_ready = 1'b1;
        model_reset();
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        total++; if (out_last !== 1'b0 || out_src !== 2'd0) begin bad++; $display("FAIL reset_last_src got=%b/%0d want=0/0", out_last, out_src); end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        // open a packet on ch1, then stall it and reset in the middle
        sel = 2'd1; in_valid = 4'b0010; in_last = 4'b0000; in_data = 32'h0000_1100;
        settle();
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL midpkt_first_ready got=%b want=0010", in_ready); end
        tick();
        out_ready = 1'b0; in_valid = 4'b0111;
        settle();
        total++; if (out_valid !== 1'b1 || in_ready !== 4'b0000) begin bad++; $display("FAIL midpkt_hold got=%b/%b want=1/0000", out_valid, in_ready); end
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin bad++; $display("FAIL async_reset got=%b/%b want=0/0000", out_valid, in_ready); end
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        // lock must be gone: sel=0 now wins instead of the old ch1 packet
        sel = 2'd0; in_valid = 4'b0011; in_last = 4'hF; out_ready = 1'b1;
        settle();
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL lock_cleared got=%b want=0001", in_ready); end
        tick();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_last = 4'hF;
        in_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
        settle();
        total++; if (in_ready !== 4'b0100 || in_ready !== m_ready) begin bad++; $display("FAIL fixed_ready got=%b want=0100", in_ready); end
        tick();
        in_valid = 4'h0;
        settle();
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2 || out_last !== 1'b1)
            begin bad++; $display("FAIL fixed_out got=%b/%h/%0d/%b want=1/a5/2/1", out_valid, out_data, out_src, out_last); end
        tick();
    endtask

    task automatic test_rr();
        int seq [5] = '{0, 1, 2, 3, 0};
        mode = 1'b1; out_ready = 1'b1; in_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'hF; in_data = $urandom;
            settle();
            if (k > 0) begin
                total++; if (out_src !== 2'(seq[k-1]) || out_valid !== 1'b1) begin bad++; $display("FAIL rr_src[%0d] got=%0d want=%0d", k-1, out_src, seq[k-1]); end
            end
            total++; if (in_ready !== 4'(4'b0001 << seq[k]) || in_ready !== m_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, in_ready, 4'(4'b0001 << seq[k])); end
            tick();
        end
        in_valid = 4'h0;
        settle();
        total++; if (out_src !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL rr_src[4] got=%0d want=0", out_src); end
        tick();
    endtask

    task automatic test_lock();
        mode = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_valid = 4'b0111;
            in_last  = {1'b1, 1'b1, (b == 2), 1'b1};
            sel      = (b % 2 == 1) ? 2'd0 : 2'd2;
            mode     = (b == 1) ? 1'b0 : 1'b1;
            in_data  = $urandom;
            settle();
            total++; if (in_ready !== 4'b0010 || in_ready !== m_ready) begin bad++; $display("FAIL lock_ready[%0d] got=%b want=0010", b, in_ready); end
            if (b > 0) begin
                total++; if (out_src !== 2'd1) begin bad++; $display("FAIL lock_src[%0d] got=%0d want=1", b-1, out_src); end
            end
            tick();
        end
        mode = 1'b1; in_valid = 4'b0111; in_last = 4'hF; in_data = $urandom;
        settle();
        total++; if (out_src !== 2'd1 || out_last !== 1'b1) begin bad++; $display("FAIL lock_last got=%0d/%b want=1/1", out_src, out_last); end
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL lock_next_grant got=%b want=0100", in_ready); end
        tick();
        in_valid = 4'h0;
        settle();
        total++; if (out_src !== 2'd2) begin bad++; $display("FAIL lock_after_src got=%0d want=2", out_src); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic [7:0] q [$];
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = $urandom;
        settle();
        tick();
        held = m_odata;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 4'($urandom); in_data = $urandom; in_last = 4'($urandom);
            settle();
            total++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 4'b0000)
                begin bad++; $display("FAIL stall[%0d] got=%b/%h/%b want=1/%h/0000", c, out_valid, out_data, in_ready, held); end
            tick();
        end
        q.push_back(held);
        out_ready = 1'b1; in_last = 4'hF;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5) ? 4'hF : 4'h0; in_data = $urandom;
            settle();
            total++; if (out_valid !== m_ovalid) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=%b", c, out_valid, m_ovalid); end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL drain_dup[%0d] got=%h want=none", c, out_data); end
                else begin
                    held = q.pop_front();
                    if (out_data !== held) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", c, out_data, held); end
                end
            end
            if (m_ready != 4'b0000) q.push_back(in_data[m_gnt*W +: W]);
            tick();
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL drain_loss got=%0d want=0", q.size()); end
    endtask

    task automatic test_idle();
        logic [1:0] pre_ptr;
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = $urandom;
        settle();
        tick();
        pre_ptr = m_ptr;
        in_valid = 4'h0;
        settle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL idle_beat got=%b want=1", out_valid); end
        tick();
        settle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", out_valid); end
        tick(); tick();
        in_valid = 4'hF;
        settle();
        total++; if (in_ready !== 4'(4'b0001 << pre_ptr)) begin bad++; $display("FAIL idle_ptr got=%b want=%b", in_ready, 4'(4'b0001 << pre_ptr)); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel      = 2'($urandom);
            in_valid = 4'($urandom);
            in_data  = $urandom;
            for (int i = 0; i < N; i++) in_last[i] = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            total++;
            if ({in_ready, out_valid, out_data, out_last, out_src} !== {m_ready, m_ovalid, m_odata, m_olast, m_osrc}) begin
                bad++;
                $display("FAIL random[%0d] got rdy=%b v=%b d=%h l=%b s=%0d want rdy=%b v=%b d=%h l=%b s=%0d",
                         c, in_ready, out_valid, out_data, out_last, out_src, m_ready, m_ovalid, m_odata, m_olast, m_osrc);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_lock();
        test_backpressure();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
